// File: rtl/vram_pkg.sv
// Shared types and default sizes for the VRAM arbiter slice.
// Tag and grant encodings are used by the arbiter top and its return pipe.
package vram_pkg;

    localparam int VRAM_RAM_WIDTH = 16;
    localparam int VRAM_ADDR_W    = 10;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_CPU_RD
    } tag_e;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_CPU
    } grant_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the display fetcher, the CPU side, the VRAM and the arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface vram_arbiter_if #(
    parameter int RAM_WIDTH = vram_pkg::VRAM_RAM_WIDTH,
    parameter int ADDR_W    = vram_pkg::VRAM_ADDR_W
) ();

    logic                 disp_fetch;
    logic [ADDR_W-1:0]    disp_addr;
    logic [RAM_WIDTH-1:0] disp_data;
    logic                 disp_valid;

    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [RAM_WIDTH-1:0] cpu_wdata;
    logic                 cpu_ack;
    logic [RAM_WIDTH-1:0] cpu_rdata;
    logic                 cpu_rvalid;

    logic [ADDR_W-1:0]    ram_addr;
    logic                 ram_we;
    logic [RAM_WIDTH-1:0] ram_wdata;
    logic [RAM_WIDTH-1:0] ram_rdata;

    modport slave (
        input  disp_fetch, disp_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output disp_data, disp_valid,
        output cpu_ack, cpu_rdata, cpu_rvalid,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output disp_fetch, disp_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  disp_data, disp_valid,
        input  cpu_ack, cpu_rdata, cpu_rvalid,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/vram_tag_pipe.sv
// Two-stage return tag pipeline: routes RAM read data to the display or CPU
// two edges after the grant that issued the read.
module vram_tag_pipe
    import vram_pkg::*;
#(
    parameter int RAM_WIDTH = VRAM_RAM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  tag_e                 tag_in,
    input  logic [RAM_WIDTH-1:0] ram_rdata,
    output logic [RAM_WIDTH-1:0] disp_data,
    output logic                 disp_valid,
    output logic [RAM_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_rvalid
);

    tag_e tag_q1;
    tag_e tag_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q1     <= TAG_NONE;
            tag_q2     <= TAG_NONE;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            tag_q1     <= tag_in;
            tag_q2     <= tag_q1;
            disp_valid <= (tag_q2 == TAG_DISP);
            cpu_rvalid <= (tag_q2 == TAG_CPU_RD);
            if (tag_q2 == TAG_DISP)
                disp_data <= ram_rdata;
            if (tag_q2 == TAG_CPU_RD)
                cpu_rdata <= ram_rdata;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Display-priority arbiter for a single-port VRAM with CPU anti-starvation.
// Optional VRAM_ARB_STATS_EN adds miss_count and force_count outputs.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int RAM_WIDTH    = VRAM_RAM_WIDTH,
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int MAX_CPU_WAIT = 4
) (
    input  logic        CLK_50,
    input  logic        RESET,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0] miss_count,
    output logic [15:0] force_count,
`endif
    vram_arbiter_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

    logic              disp_pend;
    logic [ADDR_W-1:0] pend_addr;
    logic [WAIT_W-1:0] cpu_wait;
    logic              force_cpu;
    grant_e            gnt;
    tag_e              tag;

    always_comb begin
        force_cpu = bus.cpu_req && (cpu_wait >= WAIT_MAX);
        if (force_cpu)
            gnt = GNT_CPU;
        else if (disp_pend || bus.disp_fetch)
            gnt = GNT_DISP;
        else if (bus.cpu_req)
            gnt = GNT_CPU;
        else
            gnt = GNT_IDLE;
    end

    always_comb begin
        tag = TAG_NONE;
        unique case (gnt)
            GNT_DISP: tag = TAG_DISP;
            GNT_CPU:  tag = bus.cpu_we ? TAG_NONE : TAG_CPU_RD;
            default:  tag = TAG_NONE;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
            bus.cpu_ack   <= 1'b0;
            disp_pend     <= 1'b0;
            pend_addr     <= '0;
            cpu_wait      <= '0;
        end else begin
            bus.ram_we  <= 1'b0;
            bus.cpu_ack <= 1'b0;
            unique case (gnt)
                GNT_CPU: begin
                    bus.ram_addr  <= bus.cpu_addr;
                    bus.ram_we    <= bus.cpu_we;
                    bus.ram_wdata <= bus.cpu_wdata;
                    bus.cpu_ack   <= 1'b1;
                end
                // A fresh fetch wins over the stale pending address
                GNT_DISP:
                    bus.ram_addr <= bus.disp_fetch ? bus.disp_addr : pend_addr;
                default: ;
            endcase

            if (gnt == GNT_DISP) begin
                disp_pend <= 1'b0;
            end else if (bus.disp_fetch) begin
                disp_pend <= 1'b1;
                pend_addr <= bus.disp_addr;
            end

            if (!bus.cpu_req || gnt == GNT_CPU)
                cpu_wait <= '0;
            else if (cpu_wait < WAIT_MAX)
                cpu_wait <= cpu_wait + 1'b1;
        end
    end

    vram_tag_pipe #(
        .RAM_WIDTH(RAM_WIDTH)
    ) u_tag_pipe (
        .clk       (CLK_50),
        .rst       (RESET),
        .tag_in    (tag),
        .ram_rdata (bus.ram_rdata),
        .disp_data (bus.disp_data),
        .disp_valid(bus.disp_valid),
        .cpu_rdata (bus.cpu_rdata),
        .cpu_rvalid(bus.cpu_rvalid)
    );

`ifdef VRAM_ARB_STATS_EN
    // Any new fetch landing on a still-pending one drops the older request
    logic miss;
    assign miss = bus.disp_fetch && disp_pend;

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            miss_count  <= '0;
            force_count <= '0;
        end else begin
            if (miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            if (force_cpu && force_count != 16'hFFFF)
                force_count <= force_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, reset sequence and
// randomized traffic against a transaction-level reference model.
module tb_vram_arbiter;

    localparam int RW   = 16;
    localparam int AW   = 10;
    localparam int MAXW = 4;

    logic CLK_50 = 1'b0;
    logic RESET  = 1'b1;
    always #10 CLK_50 = ~CLK_50;

    vram_arbiter_if #(.RAM_WIDTH(RW), .ADDR_W(AW)) bus ();

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] miss_count;
    logic [15:0] force_count;
`endif

    vram_arbiter #(
        .RAM_WIDTH   (RW),
        .ADDR_W      (AW),
        .MAX_CPU_WAIT(MAXW)
    ) dut (
        .CLK_50     (CLK_50),
        .RESET      (RESET),
`ifdef VRAM_ARB_STATS_EN
        .miss_count (miss_count),
        .force_count(force_count),
`endif
        .bus        (bus)
    );

    // Single-port RAM with one-cycle registered read
    logic [RW-1:0] ram [0:1023];
    always @(posedge CLK_50) begin
        if (bus.ram_we)
            ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit f, logic [AW-1:0] da, bit rq, bit w,
                         logic [AW-1:0] ca, logic [RW-1:0] wd);
        bus.disp_fetch = f;
        bus.disp_addr  = da;
        bus.cpu_req    = rq;
        bus.cpu_we     = w;
        bus.cpu_addr   = ca;
        bus.cpu_wdata  = wd;
    endtask

    task automatic tick();
        @(posedge CLK_50);
        @(negedge CLK_50);
    endtask

    typedef struct {
        bit            f;
        logic [AW-1:0] da;
        bit            rq;
        bit            w;
        logic [AW-1:0] ca;
        logic [RW-1:0] wd;
        bit            e_ack;
        bit            e_we;
        logic [AW-1:0] e_addr;
        bit            e_dv;
        logic [RW-1:0] e_dd;
        bit            e_cv;
        logic [RW-1:0] e_cd;
    } vec_t;

    function automatic vec_t mk(bit f, int da, bit rq, bit w, int ca, int wd,
                                bit ak, bit we, int ad, bit dv, int dd,
                                bit cv, int cd);
        vec_t v;
        v.f = f;  v.da = AW'(da); v.rq = rq; v.w = w;
        v.ca = AW'(ca); v.wd = RW'(wd);
        v.e_ack = ak; v.e_we = we; v.e_addr = AW'(ad);
        v.e_dv = dv; v.e_dd = RW'(dd); v.e_cv = cv; v.e_cd = RW'(cd);
        return v;
    endfunction

    vec_t vt[$];

    // Reference model state
    logic [RW-1:0] ref_mem [0:1023];
    bit            m_pend;
    int            m_paddr;
    int            m_wait;
    int            m_miss;
    int            m_force;
    int            sk [4];
    logic [RW-1:0] sv [4];

    task automatic check_reset_state(string tag);
        chk({tag, " ram_addr"},  32'(bus.ram_addr),  0);
        chk({tag, " ram_we"},    32'(bus.ram_we),    0);
        chk({tag, " ram_wdata"}, 32'(bus.ram_wdata), 0);
        chk({tag, " disp_data"}, 32'(bus.disp_data), 0);
        chk({tag, " disp_vld"},  32'(bus.disp_valid), 0);
        chk({tag, " cpu_rdata"}, 32'(bus.cpu_rdata), 0);
        chk({tag, " cpu_rvld"},  32'(bus.cpu_rvalid), 0);
        chk({tag, " cpu_ack"},   32'(bus.cpu_ack),   0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            ram[i] = RW'(16'h1000 + i);
        ram[10'h010] = 16'hA5A5;
        drive(0, 0, 0, 0, 0, 0);

        // Directed cycle table: inputs before the edge, outputs after it
        vt.push_back(mk(1,'h010,0,0,0,0,       0,0,'h010,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h010,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h010,1,'hA5A5,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h010,0,0,0,0));
        vt.push_back(mk(0,0,1,1,'h3FF,'h1234,  1,1,'h3FF,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h3FF,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h3FF,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h3FF,0,0,0,0));
        vt.push_back(mk(1,'h100,1,0,'h005,0,   0,0,'h100,0,0,0,0));
        vt.push_back(mk(1,'h101,1,0,'h005,0,   0,0,'h101,0,0,0,0));
        vt.push_back(mk(1,'h102,1,0,'h005,0,   0,0,'h102,1,'h1100,0,0));
        vt.push_back(mk(1,'h103,1,0,'h005,0,   0,0,'h103,1,'h1101,0,0));
        vt.push_back(mk(1,'h104,1,0,'h005,0,   1,0,'h005,1,'h1102,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h104,1,'h1103,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h104,0,0,1,'h1005));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h104,1,'h1104,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h104,0,0,0,0));
        vt.push_back(mk(1,'h0F0,1,0,'h006,0,   0,0,'h0F0,0,0,0,0));
        vt.push_back(mk(1,'h0F1,1,0,'h006,0,   0,0,'h0F1,0,0,0,0));
        vt.push_back(mk(1,'h0F2,1,0,'h006,0,   0,0,'h0F2,1,'h10F0,0,0));
        vt.push_back(mk(1,'h020,1,0,'h006,0,   0,0,'h020,1,'h10F1,0,0));
        vt.push_back(mk(1,'h021,1,0,'h006,0,   1,0,'h006,1,'h10F2,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h021,1,'h1020,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h021,0,0,1,'h1006));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h021,1,'h1021,0,0));
        vt.push_back(mk(1,'h0E0,1,0,'h007,0,   0,0,'h0E0,0,0,0,0));
        vt.push_back(mk(1,'h0E1,1,0,'h007,0,   0,0,'h0E1,0,0,0,0));
        vt.push_back(mk(1,'h0E2,1,0,'h007,0,   0,0,'h0E2,1,'h10E0,0,0));
        vt.push_back(mk(1,'h0E3,1,0,'h007,0,   0,0,'h0E3,1,'h10E1,0,0));
        vt.push_back(mk(1,'h030,1,0,'h007,0,   1,0,'h007,1,'h10E2,0,0));
        vt.push_back(mk(1,'h031,0,0,0,0,       0,0,'h031,1,'h10E3,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h031,0,0,1,'h1007));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h031,1,'h1031,0,0));
        vt.push_back(mk(0,0,0,0,0,0,           0,0,'h031,0,0,0,0));

        tick();
        tick();
        check_reset_state("por");
        RESET = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].f, vt[i].da, vt[i].rq, vt[i].w, vt[i].ca, vt[i].wd);
            tick();
            chk($sformatf("v%0d ack", i),  32'(bus.cpu_ack),    32'(vt[i].e_ack));
            chk($sformatf("v%0d we", i),   32'(bus.ram_we),     32'(vt[i].e_we));
            chk($sformatf("v%0d addr", i), 32'(bus.ram_addr),   32'(vt[i].e_addr));
            chk($sformatf("v%0d dv", i),   32'(bus.disp_valid), 32'(vt[i].e_dv));
            chk($sformatf("v%0d cv", i),   32'(bus.cpu_rvalid), 32'(vt[i].e_cv));
            if (vt[i].e_we)
                chk($sformatf("v%0d wdata", i), 32'(bus.ram_wdata), 32'(vt[i].wd));
            if (vt[i].e_dv)
                chk($sformatf("v%0d dd", i), 32'(bus.disp_data), 32'(vt[i].e_dd));
            if (vt[i].e_cv)
                chk($sformatf("v%0d cd", i), 32'(bus.cpu_rdata), 32'(vt[i].e_cd));
        end
`ifdef VRAM_ARB_STATS_EN
        chk("tbl miss_count",  32'(miss_count),  1);
        chk("tbl force_count", 32'(force_count), 3);
`endif

        // Reset one cycle after a CPU read grant discards the return
        drive(0, 0, 1, 0, 'h00A, 0);
        tick();
        chk("rst grant ack", 32'(bus.cpu_ack), 1);
        drive(0, 0, 0, 0, 0, 0);
        RESET = 1'b1;
        #1;
        check_reset_state("mid");
`ifdef VRAM_ARB_STATS_EN
        chk("mid miss_count", 32'(miss_count), 0);
`endif
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post rst cv%0d", k), 32'(bus.cpu_rvalid), 0);
            chk($sformatf("post rst dv%0d", k), 32'(bus.disp_valid), 0);
        end
        drive(1, 'h010, 0, 0, 0, 0);
        tick();
        chk("pr addr", 32'(bus.ram_addr), 'h010);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("pr dv early", 32'(bus.disp_valid), 0);
        tick();
        chk("pr dv", 32'(bus.disp_valid), 1);
        chk("pr dd", 32'(bus.disp_data), 'hA5A5);
        chk("pr ack", 32'(bus.cpu_ack), 0);

        // Randomized traffic against the reference model
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 1024; i++)
            ref_mem[i] = ram[i];
        m_pend = 0; m_paddr = 0; m_wait = 0; m_miss = 0; m_force = 0;
        for (int i = 0; i < 4; i++) begin
            sk[i] = 0;
            sv[i] = '0;
        end
        begin
            bit            f, rq, w, e_ack, e_we, acked;
            logic [AW-1:0] da, ca, e_addr;
            logic [RW-1:0] wd, e_wd, e_dd, e_cd;
            int            g, a, slot;
            bit            e_dv, e_cv;
            rq = 0; w = 0; ca = 0; wd = 0; acked = 0;
            e_addr = 0; e_dd = 0; e_cd = 0; e_wd = 0;
            for (int c = 0; c < 3000; c++) begin
                f  = ($urandom_range(0, 3) != 0);
                da = AW'($urandom_range(0, 15));
                if (!rq || acked) begin
                    rq = ($urandom_range(0, 2) != 0);
                    w  = $urandom_range(0, 1) == 1;
                    ca = AW'($urandom_range(0, 15));
                    wd = RW'($urandom);
                end
                drive(f, da, rq, w, ca, wd);

                // g: 0 idle, 1 display, 2 cpu
                if (rq && m_wait >= MAXW) begin
                    g = 2;
                    m_force++;
                end else if (m_pend || f) g = 1;
                else if (rq) g = 2;
                else g = 0;
                if (f && m_pend) m_miss++;
                e_ack = (g == 2);
                e_we  = (g == 2) && w;
                slot  = (c + 2) % 4;
                sk[slot] = 0;
                if (g == 1) begin
                    a = f ? int'(da) : m_paddr;
                    e_addr = AW'(a);
                    sk[slot] = 1;
                    sv[slot] = ref_mem[a];
                end else if (g == 2) begin
                    e_addr = ca;
                    if (w) begin
                        ref_mem[ca] = wd;
                        e_wd = wd;
                    end else begin
                        sk[slot] = 2;
                        sv[slot] = ref_mem[ca];
                    end
                end
                if (g == 1) m_pend = 0;
                else if (f) begin
                    m_pend  = 1;
                    m_paddr = int'(da);
                end
                if (!rq || g == 2) m_wait = 0;
                else if (m_wait < MAXW) m_wait++;
                acked = e_ack;

                tick();
                slot = c % 4;
                e_dv = (sk[slot] == 1);
                e_cv = (sk[slot] == 2);
                if (e_dv) e_dd = sv[slot];
                if (e_cv) e_cd = sv[slot];
                sk[slot] = 0;
                chk($sformatf("r%0d ack", c),  32'(bus.cpu_ack),    32'(e_ack));
                chk($sformatf("r%0d we", c),   32'(bus.ram_we),     32'(e_we));
                chk($sformatf("r%0d addr", c), 32'(bus.ram_addr),   32'(e_addr));
                if (e_we)
                    chk($sformatf("r%0d wd", c), 32'(bus.ram_wdata), 32'(e_wd));
                chk($sformatf("r%0d dv", c),   32'(bus.disp_valid), 32'(e_dv));
                chk($sformatf("r%0d dd", c),   32'(bus.disp_data),  32'(e_dd));
                chk($sformatf("r%0d cv", c),   32'(bus.cpu_rvalid), 32'(e_cv));
                chk($sformatf("r%0d cd", c),   32'(bus.cpu_rdata),  32'(e_cd));
            end
        end
`ifdef VRAM_ARB_STATS_EN
        chk("rnd miss_count",  32'(miss_count),  32'(m_miss));
        chk("rnd force_count", 32'(force_count), 32'(m_force));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
